// File: rtl/symbol_aligner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : symbol_aligner_pkg
// Purpose  : Shared PHY receive-path constants: K28.5 comma patterns in both
//            running disparities and the word-aligner state encoding. The
//            comma detector downstream uses the same comma constants.
// Revision : 1.0 - initial release
// ============================================================================
package symbol_aligner_pkg;

    // K28.5, bit 9 = 'a' (first received bit)
    localparam logic [9:0] c_COMMA_P = 10'b0011111010;  // RD-
    localparam logic [9:0] c_COMMA_N = 10'b1100000101;  // RD+

    // Aligner state encoding
    localparam int unsigned            c_STATE_W   = 2;
    localparam logic [c_STATE_W-1:0]   c_ST_HUNT   = 2'd0;
    localparam logic [c_STATE_W-1:0]   c_ST_VERIFY = 2'd1;
    localparam logic [c_STATE_W-1:0]   c_ST_LOCKED = 2'd2;

    // True when a 10-bit window holds either disparity of K28.5
    function automatic logic is_comma(input logic [9:0] win);
        return (win == c_COMMA_P) || (win == c_COMMA_N);
    endfunction

endpackage
`default_nettype wire

// File: rtl/symbol_aligner.sv
`default_nettype none
// ============================================================================
// Module   : symbol_aligner
// Purpose  : Serial-to-symbol word aligner on the recovered bit clock. Slides
//            a 10-bit window over the bit stream, hunts for K28.5 commas,
//            locks after LOCK_COMMAS commas on one boundary and then emits
//            framed 10-bit symbols with a one-cycle strobe every 10 bits.
//            Lock is lost on LOSS_COMMAS consecutive misaligned commas; a
//            candidate boundary is dropped after MAX_GAP comma-less symbols.
// Ports    : clk           - recovered bit clock
//            rst           - synchronous active-high reset
//            serial_in     - received bit, first bit of a symbol is 'a'
//            symbol_out    - aligned symbol, bit 9 = 'a', bit 0 = 'j'
//            symbol_valid  - one-cycle strobe, LOCKED only
//            locked        - high while in LOCKED
//            comma_aligned - comma seen on a boundary while LOCKED
//            realign       - boundary was moved by a candidate comma
// Revision : 1.0 - initial release
// ============================================================================
module symbol_aligner
    import symbol_aligner_pkg::*;
#(
    parameter int LOCK_COMMAS = 3,
    parameter int LOSS_COMMAS = 4,
    parameter int MAX_GAP     = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [9:0] symbol_out,
    output logic       symbol_valid,
    output logic       locked,
    output logic       comma_aligned,
    output logic       realign
);

    localparam int c_GOOD_W = $clog2(LOCK_COMMAS + 1);
    localparam int c_MISS_W = $clog2(LOSS_COMMAS + 1);
    localparam int c_GAP_W  = $clog2(MAX_GAP + 1);

    localparam logic [c_GOOD_W-1:0] c_GOOD_ONE  = c_GOOD_W'(1);
    localparam logic [c_GOOD_W-1:0] c_GOOD_MAX  = c_GOOD_W'(LOCK_COMMAS);
    localparam logic [c_GOOD_W-1:0] c_GOOD_LAST = c_GOOD_W'(LOCK_COMMAS - 1);
    localparam logic [c_MISS_W-1:0] c_MISS_MAX  = c_MISS_W'(LOSS_COMMAS);
    localparam logic [c_MISS_W-1:0] c_MISS_LAST = c_MISS_W'(LOSS_COMMAS - 1);
    localparam logic [c_GAP_W-1:0]  c_GAP_MAX   = c_GAP_W'(MAX_GAP);
    localparam logic [c_GAP_W-1:0]  c_GAP_LAST  = c_GAP_W'(MAX_GAP - 1);

    // Registered state
    logic [9:0]           r_sh;
    logic [3:0]           r_bit_cnt;
    logic [c_GOOD_W-1:0]  r_good_cnt;
    logic [c_MISS_W-1:0]  r_miss_cnt;
    logic [c_GAP_W-1:0]   r_gap_cnt;
    logic [c_STATE_W-1:0] r_state;
    logic [9:0]           r_symbol_out;
    logic                 r_symbol_valid;
    logic                 r_locked;
    logic                 r_comma_aligned;
    logic                 r_realign;

    // Next-state values
    logic [3:0]           w_bit_cnt_nxt;
    logic [c_GOOD_W-1:0]  w_good_nxt;
    logic [c_MISS_W-1:0]  w_miss_nxt;
    logic [c_GAP_W-1:0]   w_gap_nxt;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic [9:0]           w_sym_nxt;
    logic                 w_valid_nxt;
    logic                 w_aligned_nxt;
    logic                 w_realign_nxt;

    logic w_match;
    logic w_boundary;

    // Comparator works on the registered window, so a comma whose last bit
    // was sampled at edge k is acted on at edge k+1.
    assign w_match    = is_comma(r_sh);
    assign w_boundary = (r_bit_cnt == 4'd9);

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = w_boundary ? 4'd0 : (r_bit_cnt + 4'd1);
        w_good_nxt    = r_good_cnt;
        w_miss_nxt    = r_miss_cnt;
        w_gap_nxt     = r_gap_cnt;
        w_sym_nxt     = r_symbol_out;
        w_valid_nxt   = 1'b0;
        w_aligned_nxt = 1'b0;
        w_realign_nxt = 1'b0;

        case (r_state)
            c_ST_HUNT: begin
                if (w_match) begin
                    // Forcing bit_cnt to 0 here makes the comma cycle itself
                    // a boundary: the next boundary lands 10 bits later.
                    w_bit_cnt_nxt = 4'd0;
                    w_good_nxt    = c_GOOD_ONE;
                    w_gap_nxt     = '0;
                    w_realign_nxt = 1'b1;
                    if (LOCK_COMMAS == 1) begin
                        w_state_nxt = c_ST_LOCKED;
                        w_miss_nxt  = '0;
                        w_sym_nxt   = r_sh;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_VERIFY;
                    end
                end
            end

            c_ST_VERIFY: begin
                if (w_match && w_boundary) begin
                    w_gap_nxt  = '0;
                    w_good_nxt = (r_good_cnt == c_GOOD_MAX) ? r_good_cnt
                                                            : (r_good_cnt + c_GOOD_ONE);
                    if (r_good_cnt == c_GOOD_LAST) begin
                        // The locking comma is also the first emitted symbol
                        w_state_nxt = c_ST_LOCKED;
                        w_miss_nxt  = '0;
                        w_sym_nxt   = r_sh;
                        w_valid_nxt = 1'b1;
                    end
                end else if (w_match) begin
                    // Comma off the candidate boundary: it becomes the new one
                    w_bit_cnt_nxt = 4'd0;
                    w_good_nxt    = c_GOOD_ONE;
                    w_gap_nxt     = '0;
                    w_realign_nxt = 1'b1;
                end else if (w_boundary) begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        w_state_nxt = c_ST_HUNT;
                        w_gap_nxt   = '0;
                        w_good_nxt  = '0;
                    end else if (r_gap_cnt != c_GAP_MAX) begin
                        w_gap_nxt = r_gap_cnt + c_GAP_W'(1);
                    end
                end
            end

            c_ST_LOCKED: begin
                if (w_boundary) begin
                    w_sym_nxt   = r_sh;
                    w_valid_nxt = 1'b1;
                end
                if (w_match && w_boundary) begin
                    w_aligned_nxt = 1'b1;
                    w_miss_nxt    = '0;
                end else if (w_match) begin
                    if (r_miss_cnt == c_MISS_LAST) begin
                        // Too many slipped commas: adopt this one as candidate
                        w_state_nxt   = c_ST_VERIFY;
                        w_bit_cnt_nxt = 4'd0;
                        w_good_nxt    = c_GOOD_ONE;
                        w_gap_nxt     = '0;
                        w_miss_nxt    = '0;
                        w_realign_nxt = 1'b1;
                    end else if (r_miss_cnt != c_MISS_MAX) begin
                        w_miss_nxt = r_miss_cnt + c_MISS_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = c_ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh            <= '0;
            r_bit_cnt       <= '0;
            r_good_cnt      <= '0;
            r_miss_cnt      <= '0;
            r_gap_cnt       <= '0;
            r_state         <= c_ST_HUNT;
            r_symbol_out    <= '0;
            r_symbol_valid  <= 1'b0;
            r_locked        <= 1'b0;
            r_comma_aligned <= 1'b0;
            r_realign       <= 1'b0;
        end else begin
            r_sh            <= {r_sh[8:0], serial_in};
            r_bit_cnt       <= w_bit_cnt_nxt;
            r_good_cnt      <= w_good_nxt;
            r_miss_cnt      <= w_miss_nxt;
            r_gap_cnt       <= w_gap_nxt;
            r_state         <= w_state_nxt;
            r_symbol_out    <= w_sym_nxt;
            r_symbol_valid  <= w_valid_nxt;
            r_locked        <= (w_state_nxt == c_ST_LOCKED);
            r_comma_aligned <= w_aligned_nxt;
            r_realign       <= w_realign_nxt;
        end
    end

    assign symbol_out    = r_symbol_out;
    assign symbol_valid  = r_symbol_valid;
    assign locked        = r_locked;
    assign comma_aligned = r_comma_aligned;
    assign realign       = r_realign;

endmodule
`default_nettype wire

// File: tb/tb_symbol_aligner.sv
`default_nettype none
// ============================================================================
// Module   : tb_symbol_aligner
// Purpose  : Self-checking bench for symbol_aligner. Streams records of
//            {filler bits, symbol, filler bits} and checks the DUT response
//            to each record: strobes, emitted symbol, lock, comma_aligned and
//            realign pulses, plus reset behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_symbol_aligner;

    localparam logic [9:0] c_K = 10'b0011111010;   // K28.5 RD-
    localparam logic [9:0] c_D = 10'b1010101010;   // D21.5

    logic       clk;
    logic       rst;
    logic       serial_in;
    logic [9:0] symbol_out;
    logic       symbol_valid;
    logic       locked;
    logic       comma_aligned;
    logic       realign;

    symbol_aligner dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .symbol_out   (symbol_out),
        .symbol_valid (symbol_valid),
        .locked       (locked),
        .comma_aligned(comma_aligned),
        .realign      (realign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record: pre_n filler bits, a symbol (bit 9 first), post_n filler
    // bits. Expected fields describe the DUT response to this record; -1
    // means "not checked".
    typedef struct {
        int         pre_n;
        int         post_n;
        logic [9:0] sym;
        int         v;       // number of symbol_valid strobes
        logic [9:0] out;     // last strobed symbol_out
        bit         chk_out;
        int         lk;      // locked level after the record
        int         al;      // comma_aligned pulses
        int         rl;      // realign pulses
    } vec_t;

    vec_t  vq[$];
    vec_t  pend;
    bit    have_pend;
    int    pend_idx;
    string seg;

    int         win_v, win_al, win_rl;
    logic [9:0] win_out;
    int         total, bad;

    function automatic void chk(string name, int idx, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s %s rec=%0d got=%0h want=%0h", seg, name, idx, act, exp);
        end
    endfunction

    function automatic void add(int pre_n, int post_n, logic [9:0] sym, int v,
                                logic [9:0] out, bit chk_out, int lk, int al, int rl);
        vec_t r;
        r.pre_n = pre_n; r.post_n = post_n; r.sym = sym; r.v = v;
        r.out = out; r.chk_out = chk_out; r.lk = lk; r.al = al; r.rl = rl;
        vq.push_back(r);
    endfunction

    // Drive one bit, let it be sampled, then tally the DUT outputs #1 later.
    task automatic send_bit(input logic b);
        serial_in = b;
        @(posedge clk);
        #1;
        if (symbol_valid) begin
            win_v++;
            win_out = symbol_out;
        end
        if (comma_aligned) win_al++;
        if (realign)       win_rl++;
    endtask

    // Outputs trail the input by one edge, so the response to a record is
    // complete once the first bit of the following record has been clocked.
    task automatic check_pending();
        if (have_pend) begin
            if (pend.v  >= 0) chk("valid_count",   pend_idx, win_v, pend.v);
            if (pend.chk_out) chk("symbol_out",    pend_idx, int'(win_out), int'(pend.out));
            if (pend.lk >= 0) chk("locked",        pend_idx, int'(locked), pend.lk);
            if (pend.al >= 0) chk("comma_aligned", pend_idx, win_al, pend.al);
            if (pend.rl >= 0) chk("realign",       pend_idx, win_rl, pend.rl);
        end
        have_pend = 1'b0;
        win_v = 0; win_al = 0; win_rl = 0; win_out = '0;
    endtask

    task automatic run_rec(input vec_t r, input int idx);
        logic bq[$];
        for (int i = 0; i < r.pre_n; i++)  bq.push_back((i % 2) == 0);
        for (int i = 9; i >= 0; i--)       bq.push_back(r.sym[i]);
        for (int i = 0; i < r.post_n; i++) bq.push_back((i % 2) == 0);
        foreach (bq[k]) begin
            send_bit(bq[k]);
            if (k == 0) check_pending();
        end
        pend      = r;
        pend_idx  = idx;
        have_pend = 1'b1;
    endtask

    // Ends every table with an unchecked data symbol to flush the last record
    task automatic run_table();
        add(0, 0, c_D, -1, '0, 1'b0, -1, -1, -1);
        foreach (vq[i]) run_rec(vq[i], i);
        vq.delete();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        serial_in = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_symbol_out",    -1, int'(symbol_out),    0);
        chk("rst_symbol_valid",  -1, int'(symbol_valid),  0);
        chk("rst_locked",        -1, int'(locked),        0);
        chk("rst_comma_aligned", -1, int'(comma_aligned), 0);
        chk("rst_realign",       -1, int'(realign),       0);
        rst       = 1'b0;
        have_pend = 1'b0;
        win_v = 0; win_al = 0; win_rl = 0; win_out = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; have_pend = 1'b0;
        rst = 1'b1; serial_in = 1'b0;

        // ---- acquisition, data, aligned/misaligned commas, slip ----------
        seg = "acq";
        do_reset();
        add(3, 0, c_K, 0, '0,  1'b0, 0, 0,  1);   // candidate at offset 3
        add(0, 0, c_K, 0, '0,  1'b0, 0, 0,  0);   // second aligned comma
        add(0, 0, c_K, 1, c_K, 1'b1, 1, -1, 0);   // third: lock, emitted
        for (int i = 0; i < 100; i++)
            add(0, 0, c_D, 1, c_D, 1'b1, 1, 0, 0);
        // comma 5 bits off the boundary, stream framing kept intact
        for (int i = 0; i < 3; i++) add(5, 5, c_K, 2, '0, 1'b0, 1, 0, 0);
        add(0, 0, c_K, 1, c_K, 1'b1, 1, 1, 0);    // aligned comma clears misses
        for (int i = 0; i < 3; i++) add(5, 5, c_K, 2, '0, 1'b0, 1, 0, 0);
        add(0, 0, c_K, 1, c_K, 1'b1, 1, 1, 0);
        // one-bit slip: four misaligned commas drop lock
        add(1, 0, c_K, 1, '0, 1'b0, 1, 0, 0);
        add(0, 0, c_K, 1, '0, 1'b0, 1, 0, 0);
        add(0, 0, c_K, 1, '0, 1'b0, 1, 0, 0);
        add(0, 0, c_K, 1, '0, 1'b0, 0, 0, 1);
        add(0, 0, c_K, 0, '0, 1'b0, 0, 0, 0);
        add(0, 0, c_K, 1, c_K, 1'b1, 1, -1, 0);   // relocked at new offset
        run_table();

        // ---- comma starvation in VERIFY returns to HUNT ------------------
        seg = "gap64";
        do_reset();
        add(0, 0, c_K, 0, '0, 1'b0, 0, 0, 1);
        for (int i = 0; i < 64; i++) add(0, 0, c_D, 0, '0, 1'b0, 0, 0, 0);
        add(0, 0, c_K, 0, '0,  1'b0, 0, 0,  1);   // fresh candidate from HUNT
        add(0, 0, c_K, 0, '0,  1'b0, 0, 0,  0);
        add(0, 0, c_K, 1, c_K, 1'b1, 1, -1, 0);
        run_table();

        // ---- one boundary short of starvation keeps the candidate --------
        seg = "gap63";
        do_reset();
        add(0, 0, c_K, 0, '0, 1'b0, 0, 0, 1);
        for (int i = 0; i < 63; i++) add(0, 0, c_D, 0, '0, 1'b0, 0, 0, 0);
        add(0, 0, c_K, 0, '0,  1'b0, 0, 0,  0);
        add(0, 0, c_K, 1, c_K, 1'b1, 1, -1, 0);
        run_table();

        // ---- reset mid-symbol while locked --------------------------------
        seg = "midrst";
        do_reset();
        add(0, 0, c_K, 0, '0,  1'b0, 0, 0,  1);
        add(0, 0, c_K, 0, '0,  1'b0, 0, 0,  0);
        add(0, 0, c_K, 1, c_K, 1'b1, 1, -1, 0);
        add(0, 0, c_D, 1, c_D, 1'b1, 1, 0,  0);
        foreach (vq[i]) run_rec(vq[i], i);
        vq.delete();
        send_bit(1'b1);
        check_pending();
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("locked_before_rst", -1, int'(locked), 1);
        do_reset();
        add(0, 0, c_K, 0, '0,  1'b0, 0, 0,  1);
        add(0, 0, c_K, 0, '0,  1'b0, 0, 0,  0);
        add(0, 0, c_K, 1, c_K, 1'b1, 1, -1, 0);
        run_table();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
